// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: stalls, flushes
// and memory-wait freezing, plus a memory watchdog and saturating perf counters.
module pipeline_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  input  logic              ex_branch_taken,
  input  logic [ADDR_W-1:0] ex_branch_target,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              write_pc_ir,
  output logic              branch,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              id_ex_bubble,
  output logic              ex_mem_hold,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [11:0] TIMEOUT_LAST = 12'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [11:0]       wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic              grace_q, grace_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic load_use;
  logic timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  always_comb begin
    // grace_q marks the cycle after a watchdog fire, where the access counts as done
    mem_stall = mem_req && !mem_ready && !grace_q;
    load_use  = ex_is_load && (ex_rd != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    write_pc_ir  = 1'b0;
    branch       = 1'b0;
    pc_sel       = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    if (mem_stall) begin
      write_pc_ir = 1'b1;
      ex_mem_hold = 1'b1;
    end else if (ex_branch_taken) begin
      pc_sel       = 1'b1;
      branch       = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      write_pc_ir  = 1'b1;
      id_ex_bubble = 1'b1;
    end

    timeout    = (state_q == MEM_WAIT) && mem_stall && (wait_cnt_q == TIMEOUT_LAST);
    state_d    = state_q;
    wait_cnt_d = 12'd0;
    grace_d    = 1'b0;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
        end else if (timeout) begin
          state_d   = RUN;
          grace_d   = 1'b1;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 12'd1;
        end
      end
      default: state_d = RUN;
    endcase

    stall_cnt_d = sat_inc(stall_cnt_q, write_pc_ir);
    flush_cnt_d = sat_inc(flush_cnt_q, branch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= 12'd0;
      mem_err_q   <= 1'b0;
      grace_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      grace_q     <= grace_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_target = ex_branch_target;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipeline. Each cycle it decides whether the PC and IF/ID register load, hold (stall) or squash (flush), and whether a bubble enters ID/EX or EX/MEM is frozen. It covers load-use hazards, taken-branch redirects and multi-cycle data-memory waits, with a timeout watchdog and saturating performance counters. It drives the `write_pc_ir` and `branch` controls of the IF/ID register plus the PC-select mux.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters
- MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before the watchdog fires (1..2^12-1)

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- id_rs, id_rt  input  5 each  source register indices of the instruction in ID
- id_uses_rs, id_uses_rt  input  1 each  ID instruction actually reads rs / rt
- ex_is_load  input  1  instruction in EX is a load
- ex_rd  input  5  destination register of the EX instruction
- ex_branch_taken  input  1  EX resolved a taken branch or jump
- ex_branch_target  input  `InstAddrBus  redirect address from EX
- mem_req  input  1  MEM stage instruction accesses data memory this cycle
- mem_ready  input  1  data memory completes the access this cycle
- write_pc_ir  output  1  `True: hold PC and IF/ID; `False: load
- branch  output  1  `True: IF/ID instruction replaced by `ZeroWord
- pc_sel  output  1  1: next PC = pc_target; 0: sequential PC
- pc_target  output  `InstAddrBus  redirect address
- id_ex_bubble  output  1  load ZeroWord (NOP) into ID/EX
- ex_mem_hold  output  1  hold ID/EX and EX/MEM registers
- mem_err  output  1  sticky watchdog flag
- stall_cnt, flush_cnt  output  CNT_W each  saturating counters

## Operation
- FSM states: RUN, MEM_WAIT. Reset state RUN.
- RUN → MEM_WAIT when `mem_req && !mem_ready`. MEM_WAIT → RUN when `mem_ready`, or when the wait counter reaches MEM_TIMEOUT (sets mem_err).
- Priority (highest first): memory stall, branch redirect, load-use.
- Memory stall (combinational `mem_req && !mem_ready`, in either state):
  - write_pc_ir=1, ex_mem_hold=1.
  - branch=0, pc_sel=0, id_ex_bubble=0.
  - A taken branch in EX is frozen with EX and acts on the cycle mem_ready arrives.
- Branch redirect (`ex_branch_taken`, no memory stall):
  - pc_sel=1, branch=1, id_ex_bubble=1, write_pc_ir=0.
  - Squashes both wrong-path instructions (IF and ID).
  - Overrides any simultaneous load-use hazard.
- Load-use hazard (no stall, no branch):
  - Condition: `ex_is_load && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd))`.
  - Response: write_pc_ir=1, id_ex_bubble=1.
  - Lasts exactly one cycle, because the load advances to MEM.
- Otherwise all control outputs are 0.
- pc_target = ex_branch_target at all times (combinational).
- Wait counter: 12 bits, cleared in RUN, increments each MEM_WAIT cycle.
- On timeout the FSM returns to RUN and treats the access as complete for one cycle (ex_mem_hold=0 regardless of mem_ready). mem_err stays 1 until rst.
- stall_cnt: +1 on every cycle with write_pc_ir=1. flush_cnt: +1 on every cycle with branch=1. Both saturate at 2^CNT_W-1 with no wrap.

## Timing
- All control outputs are combinational from the current inputs and state: zero-cycle latency, same cycle as the hazard.
- Counters, FSM, wait counter and mem_err update on the rising clk edge.
- Reset values: state RUN, counters 0, mem_err 0. With all inputs low, every control output is 0 and pc_target follows its input.
- rst asserted mid-MEM_WAIT: immediately returns to RUN, clears counters and mem_err. Control outputs then depend only on the current inputs.
- A load-use hazard and mem stall in the same cycle: only the stall is applied. The hazard is re-evaluated after release.

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, id_rs=5, id_uses_rs=1 for one cycle → write_pc_ir=1, id_ex_bubble=1 that cycle only; stall_cnt 0→1. Same with ex_rd=0 → no stall.
- Branch: ex_branch_taken=1, ex_branch_target=0x0000_0040 → pc_sel=1, pc_target=0x40, branch=1, id_ex_bubble=1, write_pc_ir=0; flush_cnt=1. Adding a simultaneous load-use match gives the same response.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → write_pc_ir=ex_mem_hold=1 for 3 cycles, state MEM_WAIT; release on 4th cycle; stall_cnt=3.
- Branch during mem wait: ex_branch_taken held high through a 2-cycle wait → branch=0 during wait, branch=1 and pc_sel=1 on the mem_ready cycle.
- Watchdog with MEM_TIMEOUT=4: mem_req=1, mem_ready never → mem_err=1 after 4 wait cycles, FSM in RUN; mem_err stays 1 until rst pulse clears it.
- Saturation with CNT_W=4: 20 stall cycles → stall_cnt=15. Async rst mid-stream → counters 0 before the next clk edge.
